// File: rtl/regfile_mp_scoreboard.sv
// ============================================================================
// regfile_mp_scoreboard: parametrised multi-read register file with pending-write scoreboard
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp_scoreboard #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 32,
  parameter int NUM_READ     = 2,
  parameter int ZERO_REG_EN  = 1,
  parameter int ZERO_REG_IDX = 0,
  parameter int BYPASS       = 1,
  parameter int INIT_MODE    = 1,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_READ*AW-1:0]       read_reg_i,
  output logic [NUM_READ*DATA_W-1:0]   read_data_o,
  output logic [NUM_READ-1:0]          read_busy_o,
  input  logic                         register_write_valid_i,
  input  logic [AW-1:0]                write_reg_i,
  input  logic [DATA_W-1:0]            reg_write_data_i,
  input  logic                         issue_valid_i,
  input  logic [AW-1:0]                issue_reg_i,
  output logic                         ready_o,
  output logic [AW:0]                  pending_count_o
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     init_ptr_q, init_ptr_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [AW:0]       pending_count_q, pending_count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              run;
  logic              wr_ok;
  logic              iss_ok;
  logic              set_new;
  logic              clr_old;
  logic [DATA_W-1:0] init_val;

  // An index is architecturally addressable when it exists and is not the hardwired zero.
  function automatic logic idx_ok(input logic [AW-1:0] idx);
    logic in_range;
    logic is_zero;
    in_range = ({1'b0, idx} < (AW+1)'(DEPTH));
    is_zero  = (ZERO_REG_EN != 0) && (idx == AW'(ZERO_REG_IDX));
    return in_range && !is_zero;
  endfunction

  assign run      = (state_q == ST_RUN);
  assign wr_ok    = run && register_write_valid_i && idx_ok(write_reg_i);
  assign iss_ok   = run && issue_valid_i && idx_ok(issue_reg_i);
  assign init_val = (INIT_MODE != 0) ? DATA_W'(init_ptr_q) : '0;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    case (state_q)
      ST_INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == AW'(DEPTH - 1)) begin
          state_d    = ST_RUN;
          init_ptr_d = '0;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Issue is applied after write so a same-register issue+write leaves busy set.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[write_reg_i] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[issue_reg_i] = 1'b1;
    end
    set_new = iss_ok && !busy_q[issue_reg_i];
    clr_old = wr_ok && busy_q[write_reg_i] && !(iss_ok && (issue_reg_i == write_reg_i));
    pending_count_d = pending_count_q + {{AW{1'b0}}, set_new} - {{AW{1'b0}}, clr_old};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= ST_INIT;
      init_ptr_q      <= '0;
      busy_q          <= '0;
      pending_count_q <= '0;
    end else begin
      state_q         <= state_d;
      init_ptr_q      <= init_ptr_d;
      busy_q          <= busy_d;
      pending_count_q <= pending_count_d;
    end
  end

  // Storage has no reset; contents are rebuilt by the init walk instead.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (!run) begin
        mem_q[init_ptr_q] <= init_val;
      end else if (wr_ok) begin
        mem_q[write_reg_i] <= reg_write_data_i;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [AW-1:0]     rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic              rd_busy;

    assign rd_idx = read_reg_i[gi*AW +: AW];

    always_comb begin
      rd_data = '0;
      rd_busy = 1'b0;
      if (run && idx_ok(rd_idx)) begin
        if ((BYPASS != 0) && wr_ok && (write_reg_i == rd_idx)) begin
          rd_data = reg_write_data_i;
          rd_busy = iss_ok && (issue_reg_i == rd_idx);
        end else begin
          rd_data = mem_q[rd_idx];
          rd_busy = busy_q[rd_idx];
        end
      end
    end

    assign read_data_o[gi*DATA_W +: DATA_W] = rd_data;
    assign read_busy_o[gi]                  = rd_busy;
  end

  assign ready_o         = run;
  assign pending_count_o = pending_count_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp_scoreboard.sv
// Bench for regfile_mp_scoreboard: two configurations (32x2 bypass, 24x3 no bypass) driven
// in lockstep and compared against a behavioural model, plus literal spot checks.
`default_nettype none

module tb_regfile_mp_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wv  = 1'b0;
  logic [4:0]  wr  = '0;
  logic [31:0] wd  = '0;
  logic        iv  = 1'b0;
  logic [4:0]  ir  = '0;

  logic [9:0]  rrA = '0;
  logic [63:0] rdA;
  logic [1:0]  rbA;
  logic        readyA;
  logic [5:0]  cntA;

  logic [14:0] rrB = '0;
  logic [95:0] rdB;
  logic [2:0]  rbB;
  logic        readyB;
  logic [5:0]  cntB;

  int n_assert = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  logic [31:0] mmem  [2][64];
  bit          mbusy [2][64];
  int          cyc   [2];
  int          depth [2] = '{32, 24};
  bit          byp   [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  regfile_mp_scoreboard #(
    .DATA_W(32), .DEPTH(32), .NUM_READ(2), .ZERO_REG_EN(1),
    .ZERO_REG_IDX(0), .BYPASS(1), .INIT_MODE(1)
  ) dut_a (
    .clk_i(clk), .reset_i(rst),
    .read_reg_i(rrA), .read_data_o(rdA), .read_busy_o(rbA),
    .register_write_valid_i(wv), .write_reg_i(wr), .reg_write_data_i(wd),
    .issue_valid_i(iv), .issue_reg_i(ir),
    .ready_o(readyA), .pending_count_o(cntA)
  );

  regfile_mp_scoreboard #(
    .DATA_W(32), .DEPTH(24), .NUM_READ(3), .ZERO_REG_EN(1),
    .ZERO_REG_IDX(0), .BYPASS(0), .INIT_MODE(1)
  ) dut_b (
    .clk_i(clk), .reset_i(rst),
    .read_reg_i(rrB), .read_data_o(rdB), .read_busy_o(rbB),
    .register_write_valid_i(wv), .write_reg_i(wr), .reg_write_data_i(wd),
    .issue_valid_i(iv), .issue_reg_i(ir),
    .ready_o(readyB), .pending_count_o(cntB)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit mready(int d);
    return cyc[d] >= depth[d];
  endfunction

  function automatic bit legal_idx(int d, logic [4:0] idx);
    return (int'(idx) < depth[d]) && (idx != 5'd0);
  endfunction

  function automatic bit wlegal(int d);
    return wv && mready(d) && legal_idx(d, wr);
  endfunction

  function automatic bit ilegal(int d);
    return iv && mready(d) && legal_idx(d, ir);
  endfunction

  function automatic int mcount(int d);
    int s = 0;
    for (int i = 0; i < 64; i++) s += int'(mbusy[d][i]);
    return s;
  endfunction

  function automatic logic [31:0] exp_data(int d, logic [4:0] idx);
    if (!mready(d) || !legal_idx(d, idx)) return 32'd0;
    if (byp[d] && wlegal(d) && wr == idx) return wd;
    return mmem[d][idx];
  endfunction

  function automatic logic exp_busy(int d, logic [4:0] idx);
    if (!mready(d) || !legal_idx(d, idx)) return 1'b0;
    if (byp[d] && wlegal(d) && wr == idx) return ilegal(d) && (ir == idx);
    return mbusy[d][idx];
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit wl;
      bit il;
      if (rst) begin
        cyc[d] = 0;
        for (int i = 0; i < 64; i++) mbusy[d][i] = 1'b0;
      end else if (cyc[d] < depth[d]) begin
        cyc[d]++;
        if (cyc[d] == depth[d])
          for (int i = 0; i < 64; i++) mmem[d][i] = 32'(i);
      end else begin
        wl = wlegal(d);
        il = ilegal(d);
        if (wl) begin
          mmem[d][wr]  = wd;
          mbusy[d][wr] = 1'b0;
        end
        if (il) mbusy[d][ir] = 1'b1;
      end
    end
    started = 1'b1;
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("readyA", {63'd0, readyA}, {63'd0, mready(0)});
      chk("readyB", {63'd0, readyB}, {63'd0, mready(1)});
      chk("cntA", {58'd0, cntA}, 64'(mcount(0)));
      chk("cntB", {58'd0, cntB}, 64'(mcount(1)));
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("rdA%0d", p), {32'd0, rdA[p*32 +: 32]}, {32'd0, exp_data(0, rrA[p*5 +: 5])});
        chk($sformatf("rbA%0d", p), {63'd0, rbA[p]}, {63'd0, exp_busy(0, rrA[p*5 +: 5])});
      end
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("rdB%0d", p), {32'd0, rdB[p*32 +: 32]}, {32'd0, exp_data(1, rrB[p*5 +: 5])});
        chk($sformatf("rbB%0d", p), {63'd0, rbB[p]}, {63'd0, exp_busy(1, rrB[p*5 +: 5])});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    tick();
    tick();
    rst = 1'b0;
    rrA = {5'd8, 5'd4};
    #1;
    chk("pre_ready_rd", {32'd0, rdA[31:0]}, 64'd0);
    chk("rst_cnt", {58'd0, cntA}, 64'd0);
    chk("rst_ready", {63'd0, readyA}, 64'd0);

    wv = 1'b1; wr = 5'd10; wd = 32'd55; iv = 1'b1; ir = 5'd12;
    repeat (31) tick();
    wv = 1'b0; iv = 1'b0;
    #1 chk("ready_at_31", {63'd0, readyA}, 64'd0);
    tick();
    #1;
    chk("ready_at_32", {63'd0, readyA}, 64'd1);
    chk("init_rd4", {32'd0, rdA[31:0]}, 64'd4);
    chk("init_rd8", {32'd0, rdA[63:32]}, 64'd8);
    chk("init_cnt", {58'd0, cntA}, 64'd0);
    rrA = {5'd10, 5'd10};
    #1 chk("init_wr_ignored", {32'd0, rdA[31:0]}, 64'd10);

    wv = 1'b1; wr = 5'd0;  wd = 32'h10; tick();
    wr = 5'd10; wd = 32'h20; tick();
    wr = 5'd11; wd = 32'h21; tick();
    wv = 1'b0;
    rrA = {5'd11, 5'd0};
    #1;
    chk("zero_reg", {32'd0, rdA[31:0]}, 64'd0);
    chk("reg11", {32'd0, rdA[63:32]}, 64'h21);
    chk("wr_cnt", {58'd0, cntA}, 64'd0);
    rrA = {5'd11, 5'd10};
    #1 chk("reg10", {32'd0, rdA[31:0]}, 64'h20);

    rrB = {5'd0, 5'd0, 5'd10};
    wv = 1'b1; wr = 5'd10; wd = 32'hABCD;
    #1;
    chk("bypass_on", {32'd0, rdA[31:0]}, 64'hABCD);
    chk("bypass_off", {32'd0, rdB[31:0]}, 64'h20);
    tick();
    wv = 1'b0;
    #1 chk("bypass_off_next", {32'd0, rdB[31:0]}, 64'hABCD);

    iv = 1'b1; ir = 5'd5; tick();
    ir = 5'd7; tick();
    iv = 1'b0;
    rrA = {5'd7, 5'd5};
    #1;
    chk("busy_5_7", {62'd0, rbA}, 64'd3);
    chk("cnt_2", {58'd0, cntA}, 64'd2);
    wv = 1'b1; wr = 5'd5; wd = 32'h55; tick();
    wv = 1'b0;
    #1;
    chk("busy5_clr", {63'd0, rbA[0]}, 64'd0);
    chk("cnt_1", {58'd0, cntA}, 64'd1);
    iv = 1'b1; ir = 5'd7; wv = 1'b1; wr = 5'd7; wd = 32'h77;
    #1;
    chk("byp_busy7", {63'd0, rbA[1]}, 64'd1);
    chk("byp_data7", {32'd0, rdA[63:32]}, 64'h77);
    tick();
    iv = 1'b0; wv = 1'b0;
    #1;
    chk("busy7_set_wins", {63'd0, rbA[1]}, 64'd1);
    chk("cnt_still_1", {58'd0, cntA}, 64'd1);
    chk("data7", {32'd0, rdA[63:32]}, 64'h77);

    rst = 1'b1; tick();
    rst = 1'b0;
    #1;
    chk("rst_clears_cnt", {58'd0, cntA}, 64'd0);
    chk("rst_clears_ready", {63'd0, readyA}, 64'd0);
    wv = 1'b1; wr = 5'd3; wd = 32'h33; iv = 1'b1; ir = 5'd3;
    repeat (10) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    repeat (20) tick();
    wv = 1'b0; iv = 1'b0;
    repeat (11) tick();
    #1 chk("reinit_ready_31", {63'd0, readyA}, 64'd0);
    tick();
    rrA = {5'd7, 5'd3};
    #1;
    chk("reinit_ready_32", {63'd0, readyA}, 64'd1);
    chk("reinit_cnt", {58'd0, cntA}, 64'd0);
    chk("reinit_rd3", {32'd0, rdA[31:0]}, 64'd3);
    chk("reinit_rd7", {32'd0, rdA[63:32]}, 64'd7);
    chk("reinit_busy", {62'd0, rbA}, 64'd0);

    rrB = {5'd30, 5'd30, 5'd30};
    rrA = {5'd7, 5'd30};
    wv = 1'b1; wr = 5'd30; wd = 32'h99; iv = 1'b1; ir = 5'd30;
    #1;
    chk("oob_rd", {32'd0, rdB[31:0]}, 64'd0);
    chk("oob_busy", {61'd0, rbB}, 64'd0);
    tick();
    wv = 1'b0; iv = 1'b0;
    #1;
    chk("oob_cnt", {58'd0, cntB}, 64'd0);
    chk("oob_rd_after", {32'd0, rdB[95:64]}, 64'd0);
    chk("a30_data", {32'd0, rdA[31:0]}, 64'h99);
    chk("a30_busy", {63'd0, rbA[0]}, 64'd1);
    chk("a30_cnt", {58'd0, cntA}, 64'd1);
    rrB = {5'd9, 5'd9, 5'd9};
    #1;
    for (int p = 0; p < 3; p++)
      chk($sformatf("same_idx%0d", p), {32'd0, rdB[p*32 +: 32]}, 64'd9);

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
